bcd_dabble_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Next generation of the combinational 8-bit bcd converter that sits between the factorial result and the pmod_spi display driver.
- Generalised input width and digit count; adds a start/busy/done handshake, overflow saturation and a leading-zero mask for the display.
- One shift per clock, so wide inputs do not create a long combinational path at 100 MHz.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bcd_dabble_seq.sv | 75 +++++++
 tb/tb_bcd_dabble_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding, BCD adjust constants and width helper
package bcd_pkg;
  typedef enum logic {IDLE, CONV} state_t;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD = 4'd3;
  localparam logic [3:0] BCD_NINE = 4'd9;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add 3 to a BCD digit of 5 or more ahead of the doubling shift
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;
endmodule

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: one-shift-per-clock double-dabble converter with saturation and leading-zero mask
module bcd_dabble_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  overflow
);
  localparam int BW4 = 4 * DIGITS;
  localparam int W = BW4 + BIN_WIDTH;
  localparam int CW = clog2(BIN_WIDTH + 1);
  state_t state, state_nx;
  logic [W-1:0] work, shifted;
  logic [BW4-1:0] adj, sat;
  logic [CW-1:0] cnt;
  logic ovf_sticky, ovf_nx, last, nz;
  logic [DIGITS-1:0] dv_nx;
  genvar d;
  for (d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (.din(work[BIN_WIDTH+4*d +: 4]), .dout(adj[4*d +: 4]));
  end
  // the bit leaving the top digit means the value no longer fits
  always_comb begin
    shifted = {adj[BW4-2:0], work[BIN_WIDTH-1:0], 1'b0};
    ovf_nx = ovf_sticky | adj[BW4-1];
    last = cnt == CW'(1);
    state_nx = (state == IDLE) ? (start ? CONV : IDLE) : (last ? IDLE : CONV);
    sat = {DIGITS{BCD_NINE}};
    nz = 1'b0;
    dv_nx = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (shifted[BIN_WIDTH+4*i +: 4] != 4'd0);
      dv_nx[i] = nz;
    end
    dv_nx[0] = 1'b1;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      bcd_out <= '0;
      digit_valid <= DIGITS'(1);
      overflow <= 1'b0;
      work <= '0;
      cnt <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      done <= (state == CONV) && last;
      if (state == IDLE && start) begin
        work <= W'(bin);
        cnt <= CW'(BIN_WIDTH);
        ovf_sticky <= 1'b0;
      end else if (state == CONV) begin
        work <= shifted;
        cnt <= cnt - 1'b1;
        ovf_sticky <= ovf_nx;
        if (last) begin
          bcd_out <= ovf_nx ? sat : shifted[W-1:BIN_WIDTH];
          digit_valid <= ovf_nx ? '1 : dv_nx;
          overflow <= ovf_nx;
        end
      end
    end
  end
  assign busy = (state == CONV);
endmodule

// File: tb/tb_bcd_dabble_seq.sv
// tb_bcd_dabble_seq: scoreboard bench over three parameterisations of the converter
module tb_bcd_dabble_seq;
  typedef struct packed {
    logic [19:0] bcd;
    logic [4:0]  dv;
    logic        ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [15:0] bin_a = '0, bin_b = '0;
  logic [7:0] bin_c = '0;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
  logic [19:0] bcd_a;
  logic [11:0] bcd_b, bcd_c;
  logic [4:0] dv_a;
  logic [2:0] dv_b, dv_c;
  logic busy_m, done_m, ovf_m;
  logic [19:0] bcd_m;
  logic [4:0] dv_m;
  int sel = 0;
  int cyc = 0;
  int acc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bcd_dabble_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .busy(busy_a), .done(done_a),
    .bcd_out(bcd_a), .digit_valid(dv_a), .overflow(ovf_a));
  bcd_dabble_seq #(.BIN_WIDTH(16), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .busy(busy_b), .done(done_b),
    .bcd_out(bcd_b), .digit_valid(dv_b), .overflow(ovf_b));
  bcd_dabble_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .busy(busy_c), .done(done_c),
    .bcd_out(bcd_c), .digit_valid(dv_c), .overflow(ovf_c));
  always_comb begin
    busy_m = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
    done_m = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
    ovf_m = sel == 0 ? ovf_a : sel == 1 ? ovf_b : ovf_c;
    bcd_m = sel == 0 ? bcd_a : sel == 1 ? {8'h0, bcd_b} : {8'h0, bcd_c};
    dv_m = sel == 0 ? dv_a : sel == 1 ? {2'b0, dv_b} : {2'b0, dv_c};
  end
  function automatic exp_t model(input int val, input int digits);
    exp_t e;
    int lim, v, p;
    e = '0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (val >= lim) begin
      for (int i = 0; i < digits; i++) e.bcd[4*i +: 4] = 4'd9;
      for (int i = 0; i < digits; i++) e.dv[i] = 1'b1;
      e.ovf = 1'b1;
    end else begin
      v = val;
      p = 1;
      for (int i = 0; i < digits; i++) begin
        e.bcd[4*i +: 4] = 4'(v % 10);
        v = v / 10;
        e.dv[i] = (i == 0) || (val / p != 0);
        p = p * 10;
      end
    end
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input int s, input logic st, input int val);
    if (s == 0) begin start_a = st; bin_a = 16'(val); end
    else if (s == 1) begin start_b = st; bin_b = 16'(val); end
    else begin start_c = st; bin_c = 8'(val); end
  endtask
  task automatic start_only(input int s, input int val, input int digits, input bit push);
    sel = s;
    set_in(s, 1'b1, val);
    if (push) q.push_back(model(val, digits));
    @(posedge clk);
    #1;
    acc = cyc;
    set_in(s, 1'b0, val);
  endtask
  task automatic wait_done(input string tag, input int bw, output int bc);
    exp_t e;
    bc = busy_m ? 1 : 0;
    while (!done_m && cyc - acc <= 100) begin
      @(posedge clk);
      #1;
      if (busy_m) bc++;
    end
    chk({tag, "_latency"}, 32'(cyc - acc), 32'(bw));
    if (q.size() == 0) chk({tag, "_scoreboard_empty"}, 32'(q.size()), 32'd1);
    else begin
      e = q.pop_front();
      chk({tag, "_bcd"}, {12'h0, bcd_m}, {12'h0, e.bcd});
      chk({tag, "_dv"}, {27'h0, dv_m}, {27'h0, e.dv});
      chk({tag, "_ovf"}, {31'h0, ovf_m}, {31'h0, e.ovf});
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, {31'h0, done_m}, 32'd0);
  endtask
  task automatic count_done(input int n, output int dn);
    dn = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done_m) dn++;
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {31'h0, busy_m}, 32'd0);
    chk({tag, "_done"}, {31'h0, done_m}, 32'd0);
    chk({tag, "_bcd"}, {12'h0, bcd_m}, 32'd0);
    chk({tag, "_dv"}, {27'h0, dv_m}, 32'd1);
    chk({tag, "_ovf"}, {31'h0, ovf_m}, 32'd0);
  endtask
  initial begin
    int bc, dn, d1, d2, n;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 0;
    chk_reset("reset_a");
    sel = 2;
    chk_reset("reset_c");
    start_only(0, 0, 5, 1);
    wait_done("zero", 16, bc);
    chk("zero_busy_len", 32'(bc), 32'd16);
    start_only(0, 65535, 5, 1);
    wait_done("full_scale", 16, bc);
    start_only(0, 10203, 5, 1);
    wait_done("inner_zeros", 16, bc);
    start_only(0, 42, 5, 1);
    repeat (3) @(posedge clk);
    #1;
    set_in(0, 1'b1, 99);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 99);
    wait_done("ignored_start", 16, bc);
    count_done(20, dn);
    chk("ignored_no_extra_done", 32'(dn), 32'd0);
    sel = 0;
    set_in(0, 1'b1, 7);
    n = 0;
    while (!done_m && n < 40) begin @(posedge clk); #1; n++; end
    d1 = cyc;
    @(posedge clk);
    #1;
    n = 0;
    while (!done_m && n < 40) begin @(posedge clk); #1; n++; end
    d2 = cyc;
    set_in(0, 1'b0, 7);
    chk("held_period", 32'(d2 - d1), 32'd17);
    chk("held_bcd", {12'h0, bcd_m}, 32'h00007);
    @(posedge clk);
    #1;
    chk("held_release_idle", {31'h0, busy_m}, 32'd0);
    start_only(0, 12345, 5, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("mid_reset");
    count_done(20, dn);
    chk("mid_reset_no_done", 32'(dn), 32'd0);
    start_only(0, 500, 5, 1);
    wait_done("after_reset", 16, bc);
    start_only(1, 999, 3, 1);
    wait_done("d3_999", 16, bc);
    start_only(1, 1000, 3, 1);
    wait_done("d3_1000_sat", 16, bc);
    start_only(1, 7, 3, 1);
    wait_done("d3_7", 16, bc);
    start_only(2, 120, 3, 1);
    wait_done("w8_120", 8, bc);
    start_only(2, 24, 3, 1);
    wait_done("w8_24", 8, bc);
    start_only(2, 255, 3, 1);
    wait_done("w8_255", 8, bc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
